// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder1.sv
// Single-bit full adder cell, purely combinational.
module full_adder1 (
  input  logic Ai,
  input  logic Bi,
  input  logic Ci,
  output logic So,
  output logic Co
);

  assign So = Ai ^ Bi ^ Ci;
  assign Co = (Ai & Bi) | (Ci & (Ai ^ Bi));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: time-shares one full adder across WIDTH bit positions,
// LSB first, with valid/ready handshakes on both sides.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_shift;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_so;
  logic             fa_co;
  logic             accept;

  full_adder1 u_full_adder1 (
    .Ai(op_a[0]),
    .Bi(op_b[0]),
    .Ci(carry),
    .So(fa_so),
    .Co(fa_co)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_CALC) || (state == ST_DONE);
  assign sum       = acc;
  assign cout      = carry;
  assign accept    = in_valid && (state == ST_IDLE);

  // New sum bit enters at the MSB; written this way so WIDTH = 1 is legal.
  assign acc_shift = (acc >> 1) | (WIDTH'(fa_so) << (WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)                    state_next = ST_CALC;
      ST_CALC: if (cnt == CNT_W'(WIDTH - 1))    state_next = ST_DONE;
      ST_DONE: if (out_ready)                   state_next = ST_IDLE;
      default:                                  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a  <= a;
        op_b  <= b;
        carry <= cin;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == ST_CALC) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        acc   <= acc_shift;
        carry <= fa_co;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
